// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard
//   Register scoreboard and hazard controller that sits beside the decode stage.
//   Each architectural register has one pending-write entry: a busy bit and a latency
//   countdown. Decode is stalled on RAW hazards against results not yet on the bypass
//   network, and on WAW hazards that would let a younger write retire first. A busy
//   entry whose countdown has reached zero is served from the bypass network.
//
// Parameters
//   REG_AW  register index width (NREG = 2**REG_AW entries, entry 0 never busy)
//   LAT_W   countdown width (legal id_lat 1 .. 2**LAT_W-1; 0 is treated as 1)
//   NWB     number of writeback ports
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   id_*              decode-stage instruction: valid, sources and use flags, destination,
//                     write flag, result latency
//   flush             kill the decode-stage instruction (suppresses issue only)
//   wb_valid, wb_rd   per-port writeback strobes and packed indices
//   stall, issue      hold decode / instruction accepted this cycle
//   fwd_a, fwd_b      source taken from the bypass network
//   busy_vec          registered busy bits
//   stall_cnt,        saturating stall-cycle and WAW-stall-cycle counters; present only when
//   waw_cnt           the SB_STATS_EN macro is defined
module pipeline_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned LAT_W  = 4,
    parameter int unsigned NWB    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs,
    input  logic [REG_AW-1:0]       id_rt,
    input  logic                    id_rs_used,
    input  logic                    id_rt_used,
    input  logic                    id_wr,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic [LAT_W-1:0]        id_lat,
    input  logic                    flush,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*REG_AW-1:0]   wb_rd,
    output logic                    stall,
    output logic                    issue,
    output logic                    fwd_a,
    output logic                    fwd_b,
`ifdef SB_STATS_EN
    output logic [31:0]             stall_cnt,
    output logic [15:0]             waw_cnt,
`endif
    output logic [2**REG_AW-1:0]    busy_vec
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]  busy_q, busy_d;
    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];

    logic [NREG-1:0]  wb_hit;
    logic [LAT_W-1:0] lat_eff;
    logic             rs_live, rt_live, rd_live;
    logic             raw_a, raw_b, waw;
    logic             rs_ready, rt_ready;

    // Registers being written back this cycle; index 0 is never a target.
    always_comb begin
        wb_hit = '0;
        for (int k = 0; k < int'(NWB); k++) begin
            if (wb_valid[k] && (wb_rd[k*REG_AW +: REG_AW] != '0)) begin
                wb_hit[wb_rd[k*REG_AW +: REG_AW]] = 1'b1;
            end
        end
    end

    // A latency of 0 is illegal and handled as a single-cycle result.
    assign lat_eff = (id_lat == '0) ? LAT_W'(1) : id_lat;

    assign rs_live = id_rs_used && (id_rs != '0) && busy_q[id_rs] && !wb_hit[id_rs];
    assign rt_live = id_rt_used && (id_rt != '0) && busy_q[id_rt] && !wb_hit[id_rt];
    assign rd_live = id_wr && (id_rd != '0) && busy_q[id_rd];

    // Same-cycle writeback is not a hazard: the register file is write-before-read.
    assign raw_a    = rs_live && (cnt_q[id_rs] != '0);
    assign raw_b    = rt_live && (cnt_q[id_rt] != '0);
    assign rs_ready = rs_live && (cnt_q[id_rs] == '0);
    assign rt_ready = rt_live && (cnt_q[id_rt] == '0);

    // A new write must not land before the pending one to the same register.
    assign waw = rd_live && (cnt_q[id_rd] >= lat_eff);

    assign stall    = id_valid && (raw_a || raw_b || waw);
    assign issue    = id_valid && !stall && !flush;
    assign fwd_a    = !stall && rs_ready;
    assign fwd_b    = !stall && rt_ready;
    assign busy_vec = busy_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        for (int r = 1; r < NREG; r++) begin
            if (busy_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (wb_hit[r]) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
        end
        // Issue overrides a same-cycle writeback to the same register.
        if (issue && id_wr && (id_rd != '0)) begin
            busy_d[id_rd] = 1'b1;
            cnt_d[id_rd]  = lat_eff - 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef SB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            waw_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (stall && waw && (waw_cnt != '1)) begin
                waw_cnt <= waw_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
